// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate-extension pipeline.
// Mode encodings match the 2-bit in_mode field driven by decode.
package imm_ext_pkg;

   typedef enum logic [1:0] {
      MODE_SIGN   = 2'b00,
      MODE_ZERO   = 2'b01,
      MODE_UPPER  = 2'b10,
      MODE_BRANCH = 2'b11
   } mode_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: (imm, mode) -> OUT_W-bit operand.
// IN_W <= OUT_W-2 means the BRANCH shift never drops significant bits.
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  imm,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] operand
);

   logic [OUT_W-1:0] sext;

   assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

   always_comb begin
      operand = sext;
      case (mode_t'(mode))
         MODE_SIGN:   operand = sext;
         MODE_ZERO:   operand = {{(OUT_W-IN_W){1'b0}}, imm};
         MODE_UPPER:  operand = {imm, {(OUT_W-IN_W){1'b0}}};
         MODE_BRANCH: operand = {sext[OUT_W-3:0], 2'b00};
         default:     operand = sext;
      endcase
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate-extension stage: extends at acceptance and carries the finished
// operand plus tag through a two-entry skid buffer with flush.
module imm_ext_pipe
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);

   logic [OUT_W-1:0] ext_operand;

   logic             main_valid_q, main_valid_d;
   logic [OUT_W-1:0] main_data_q,  main_data_d;
   logic [TAG_W-1:0] main_tag_q,   main_tag_d;
   logic             skid_valid_q, skid_valid_d;
   logic [OUT_W-1:0] skid_data_q,  skid_data_d;
   logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
   logic             accept;

   imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
      .imm     (in_imm),
      .mode    (in_mode),
      .operand (ext_operand)
   );

   // Ready comes from registered state only, so no out_ready -> in_ready path.
   assign in_ready  = !skid_valid_q;
   assign accept    = in_valid && in_ready && !flush;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign out_tag   = main_tag_q;

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_tag_d   = main_tag_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_tag_d   = skid_tag_q;
      if (flush) begin
         // Payload is left untouched; only the valid bits are squashed.
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         if (out_ready) begin
            main_data_d  = skid_data_q;
            main_tag_d   = skid_tag_q;
            skid_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!main_valid_q || out_ready) begin
            main_valid_d = 1'b1;
            main_data_d  = ext_operand;
            main_tag_d   = in_tag;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = ext_operand;
            skid_tag_d   = in_tag;
         end
      end else if (main_valid_q && out_ready) begin
         main_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_tag_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_tag_q   <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_tag_q   <= main_tag_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_tag_q   <= skid_tag_d;
      end
   end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: stimulus pushes expected operands,
// a negedge monitor pops and compares on every downstream transfer.
module tb_imm_ext_pipe;

   localparam int IN_W  = 16;
   localparam int OUT_W = 32;
   localparam int TAG_W = 5;

   typedef struct {
      logic [OUT_W-1:0] data;
      logic [TAG_W-1:0] tag;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [IN_W-1:0]  in_imm;
   logic [1:0]       in_mode;
   logic [TAG_W-1:0] in_tag;
   logic [OUT_W-1:0] out_data;
   logic [TAG_W-1:0] out_tag;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   pops  = 0;

   imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_imm    (in_imm),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Monitor: a transfer at the coming edge is visible at the preceding negedge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got data %0h tag %0h want none", out_data, out_tag);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            pops++;
            chk("out_data", 64'(out_data), 64'(e.data));
            chk("out_tag", 64'(out_tag), 64'(e.tag));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one immediate, wait (bounded) for in_ready, push expected on accept.
   task automatic send(input logic [IN_W-1:0] imm, input logic [1:0] mode,
                       input logic [TAG_W-1:0] tag, input logic [OUT_W-1:0] exp);
      int n;
      exp_t e;
      in_valid = 1'b1;
      in_imm   = imm;
      in_mode  = mode;
      in_tag   = tag;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         chk("send_timeout", 64'(0), 64'(1));
      end else begin
         e.data = exp;
         e.tag  = tag;
         sb_q.push_back(e);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("drain_empty", 64'(sb_q.size()), 64'(0));
   endtask

   initial begin
      int p0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_imm = '0; in_mode = 2'b00; in_tag = '0;
      tick(); tick();
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_out_tag", 64'(out_tag), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      rst = 1'b0;
      tick();

      // Directed modes with one-cycle latency check.
      out_ready = 1'b1;
      send(16'h8001, 2'b00, 5'd3, 32'hFFFF8001);
      chk("lat_sign", 64'(out_valid), 64'(1));
      send(16'h8001, 2'b01, 5'd4, 32'h00008001);
      chk("lat_zero", 64'(out_valid), 64'(1));
      send(16'h1234, 2'b10, 5'd5, 32'h12340000);
      send(16'hFFFF, 2'b11, 5'd6, 32'hFFFFFFFC);
      send(16'h7FFF, 2'b11, 5'd7, 32'h0001FFFC);
      drain();

      // Backpressure: third immediate is held upstream.
      out_ready = 1'b0;
      send(16'd1, 2'b01, 5'd1, 32'd1);
      send(16'd2, 2'b01, 5'd2, 32'd2);
      in_valid = 1'b1; in_imm = 16'd3; in_mode = 2'b01; in_tag = 5'd3;
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      tick(); tick();
      chk("bp_hold_ready", 64'(in_ready), 64'(0));
      chk("bp_hold_valid", 64'(out_valid), 64'(1));
      out_ready = 1'b1;
      tick();
      chk("bp_ready_back", 64'(in_ready), 64'(1));
      send(16'd3, 2'b01, 5'd3, 32'd3);
      drain();

      // Full throughput: 8 operands in 8 consecutive cycles.
      p0 = pops;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_t e;
         in_imm = IN_W'(16'h0100 + i); in_mode = 2'b01; in_tag = TAG_W'(i);
         chk("tp_in_ready", 64'(in_ready), 64'(1));
         if (i > 0) chk("tp_out_valid", 64'(out_valid), 64'(1));
         e.data = 32'h0100 + 32'(i);
         e.tag  = TAG_W'(i);
         sb_q.push_back(e);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("tp_count", 64'(pops - p0), 64'(8));

      // Flush in FULL while offering an input.
      out_ready = 1'b0;
      send(16'hAAAA, 2'b01, 5'd10, 32'h0000AAAA);
      send(16'hBBBB, 2'b01, 5'd11, 32'h0000BBBB);
      chk("full_in_ready", 64'(in_ready), 64'(0));
      flush = 1'b1; in_valid = 1'b1; in_imm = 16'hCCCC; in_tag = 5'd12;
      tick();
      sb_q.delete();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 64'(0));
      chk("flush_in_ready", 64'(in_ready), 64'(1));
      out_ready = 1'b1;
      tick(); tick(); tick();
      chk("flush_quiet", 64'(out_valid), 64'(0));

      // Reset mid-stream with two entries buffered.
      out_ready = 1'b0;
      send(16'h1111, 2'b01, 5'd1, 32'h00001111);
      send(16'h2222, 2'b01, 5'd2, 32'h00002222);
      rst = 1'b1;
      tick();
      sb_q.delete();
      rst = 1'b0;
      chk("mrst_out_valid", 64'(out_valid), 64'(0));
      chk("mrst_out_data", 64'(out_data), 64'(0));
      chk("mrst_in_ready", 64'(in_ready), 64'(1));
      out_ready = 1'b1;
      send(16'h0005, 2'b01, 5'd9, 32'h00000005);
      drain();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate-extension stage for the decode path. Takes an IN_W-bit instruction immediate plus a 2-bit mode, produces an OUT_W-bit operand (sign-extend, zero-extend, upper-load placement, or branch-offset sign-extend with shift-left-2). A two-entry skid buffer with valid/ready handshakes on both sides and a synchronous flush carries the operand and a pass-through tag. This lets decode stall or squash without losing data.

## Interface
- IN_W, 16, immediate width; legal range 2..OUT_W-2
- OUT_W, 32, operand width
- TAG_W, 5, width of the side-band tag (e.g. destination register index) carried with each operand
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  synchronous squash of all buffered entries
- in_valid  input  1  upstream offers an immediate
- in_ready  output  1  block can accept this cycle
- in_imm  input  IN_W  raw immediate
- in_mode  input  2  extension mode
- in_tag  input  TAG_W  side-band tag
- out_valid  output  1  operand available
- out_ready  input  1  downstream consumes this cycle
- out_data  output  OUT_W  extended operand
- out_tag  output  TAG_W  tag belonging to out_data

## Operation
- Modes:
  - 2'b00 SIGN: out = {(OUT_W-IN_W){imm[IN_W-1]}, imm}.
  - 2'b01 ZERO: out = {(OUT_W-IN_W){0}, imm}.
  - 2'b10 UPPER: imm occupies bits [OUT_W-1 : OUT_W-IN_W]; low bits are 0.
  - 2'b11 BRANCH: sign-extend to OUT_W, then shift left 2, truncated to OUT_W.
- The width constraint guarantees BRANCH loses no significant bits.
- Extension is computed at acceptance; the buffers store finished operands, never raw immediates.
- Storage:
  - main register (drives out_*, valid = out_valid)
  - skid register (skid_valid)
- in_ready = !skid_valid. It depends only on registered state, never combinationally on out_ready.
- A transfer occurs on valid && ready at each side.
- Per-cycle update, with flush and rst not asserted:
  - Skid valid and out_ready: main ← skid; skid empties. No input acceptance this cycle.
  - Input accepted and (main empty or out_ready): main ← new operand.
  - Input accepted, main full and !out_ready: skid ← new operand.
  - Main full and out_ready, with no input accepted: main empties.
- States by {out_valid, skid_valid}: EMPTY (0,0), ONE (1,0), FULL (1,1). (0,1) is illegal and unreachable.
- Order is strictly preserved. Out of ONE, sustained throughput is one operand per cycle.
- flush:
  - Clears out_valid and skid_valid at the next edge.
  - Any input offered in the flush cycle is dropped, even if in_ready = 1.
  - A downstream transfer in the flush cycle still counts as consumed.
- rst has priority over flush.
- out_data and out_tag hold their last value when invalid; they are not cleared by flush.

## Timing
- Reset values: out_valid 0, out_data 0, out_tag 0, skid_valid 0. in_ready reads 1 once skid is clear.
- Inputs offered while rst is high are ignored.
- Latency: an input accepted at edge N appears on out_* in the cycle after edge N (1 cycle).
- From FULL, in_ready returns to 1 the cycle after the first out_ready.
- Reset or flush mid-stream: all in-flight operands are lost; state is EMPTY after the edge.

## Structure
- Package imm_ext_pkg holds:
  - mode constants MODE_SIGN / MODE_ZERO / MODE_UPPER / MODE_BRANCH
  - the 2-bit mode typedef
- Sub-module imm_ext_core: purely combinational (imm, mode) → operand, parametrised on IN_W/OUT_W.
- The top module holds only the skid/handshake logic.

## Test plan
- SIGN/ZERO: imm 16'h8001 tag 3 → out 32'hFFFF8001 tag 3. ZERO of 16'h8001 → 32'h00008001, one cycle after acceptance.
- UPPER/BRANCH: imm 16'h1234 UPPER → 32'h12340000. imm 16'hFFFF BRANCH → 32'hFFFFFFFC. imm 16'h7FFF BRANCH → 32'h0001FFFC.
- Backpressure: stream imm 1,2,3 with out_ready=0.
  - in_ready drops after 2 accepts; imm 3 is held upstream.
  - Raise out_ready: outputs 1,2,3 in order, no loss or duplicate.
- Full throughput: in_valid and out_ready held 1 for 8 cycles → 8 operands out in 8 consecutive cycles; in_ready stays 1.
- Flush in FULL state while in_valid=1 → next cycle out_valid=0 and in_ready=1; the offered imm never appears.
- Reset mid-stream with 2 entries buffered → out_valid 0 and out_data 0 after the edge. A new imm 16'h0005 ZERO then yields 32'h00000005.
